// File: rtl/mine_reader.sv
// mine_reader
// ------------
// Scans the active dimension_size x dimension_size area of the mine board one
// cell per clock. For each cell it stores the number of adjacent mines in an
// internal table, then answers single-cell queries.
//
// Optional feature macro: MINE_READER_TOTAL_EN
//   defined   -> total_mines accumulates the mines inside the active area
//   undefined -> total_mines is tied to 0
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   start           one-cycle pulse, begins a scan (taken in IDLE or READY)
//   dimension_size  active board side, sampled on start, clamped to MAX_DIM
//   board_in        mine map [x][y], 1 = mine, stable from start until ready
//   busy, ready     scanning / table valid
//   rd_req, rd_x, rd_y                  query request
//   rd_valid, rd_mine, rd_count, rd_oob query response
//   total_mines     mines inside the active area (see macro above)
//   state_dbg       current FSM state, for observation only
//
// Query handshake: rd_req has no back-pressure. A request sampled on a clock
// edge while in READY (and without start) is answered by rd_valid high for
// exactly the following cycle with the response fields registered on that
// same edge. Requests outside READY are dropped, not queued. Response fields
// hold their last value while rd_valid is low.

module mine_reader #(
  parameter int MAX_DIM = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [4:0]        dimension_size,
  input  logic [15:0][15:0] board_in,
  output logic              busy,
  output logic              ready,
  input  logic              rd_req,
  input  logic [4:0]        rd_x,
  input  logic [4:0]        rd_y,
  output logic              rd_valid,
  output logic              rd_mine,
  output logic [3:0]        rd_count,
  output logic              rd_oob,
  output logic [8:0]        total_mines,
  output logic [1:0]        state_dbg
);

  localparam int         IDX_W = (MAX_DIM > 1) ? $clog2(MAX_DIM) : 1;
  localparam logic [4:0] MAX_D = 5'(MAX_DIM);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SCAN  = 2'd1;
  localparam logic [1:0] ST_READY = 2'd2;

  logic [1:0] state_q;
  logic [4:0] d_q;
  logic [4:0] x_q;
  logic [4:0] y_q;
  logic [3:0] table_q [MAX_DIM][MAX_DIM];

  logic [4:0] d_next;
  assign d_next = (dimension_size > MAX_D) ? MAX_D : dimension_size;

  assign busy      = (state_q == ST_SCAN);
  assign ready     = (state_q == ST_READY);
  assign state_dbg = state_q;

  // Neighbour count for the cell currently being scanned. Wrapped +/-1
  // coordinates are harmless because the edge flags mask them out.
  logic       x_lo_ok, x_hi_ok, y_lo_ok, y_hi_ok;
  logic [3:0] xc, xm, xp, yc, ym, yp;
  logic [7:0] nb;
  logic [3:0] nb_count;

  always_comb begin
    xc      = x_q[3:0];
    yc      = y_q[3:0];
    xm      = xc - 4'd1;
    xp      = xc + 4'd1;
    ym      = yc - 4'd1;
    yp      = yc + 4'd1;
    x_lo_ok = (x_q != 5'd0);
    y_lo_ok = (y_q != 5'd0);
    x_hi_ok = ((x_q + 5'd1) < d_q);
    y_hi_ok = ((y_q + 5'd1) < d_q);

    nb[0] = x_lo_ok && y_lo_ok && board_in[xm][ym];
    nb[1] =            y_lo_ok && board_in[xc][ym];
    nb[2] = x_hi_ok && y_lo_ok && board_in[xp][ym];
    nb[3] = x_lo_ok            && board_in[xm][yc];
    nb[4] = x_hi_ok            && board_in[xp][yc];
    nb[5] = x_lo_ok && y_hi_ok && board_in[xm][yp];
    nb[6] =            y_hi_ok && board_in[xc][yp];
    nb[7] = x_hi_ok && y_hi_ok && board_in[xp][yp];

    nb_count = 4'd0;
    for (int i = 0; i < 8; i++) begin
      nb_count = nb_count + 4'(nb[i]);
    end
  end

  logic q_in_range;
  assign q_in_range = (rd_x < d_q) && (rd_y < d_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      d_q      <= 5'd0;
      x_q      <= 5'd0;
      y_q      <= 5'd0;
      rd_valid <= 1'b0;
      rd_mine  <= 1'b0;
      rd_count <= 4'd0;
      rd_oob   <= 1'b0;
      for (int i = 0; i < MAX_DIM; i++) begin
        for (int j = 0; j < MAX_DIM; j++) begin
          table_q[i][j] <= 4'd0;
        end
      end
    end else begin
      rd_valid <= 1'b0;
      case (state_q)
        ST_IDLE, ST_READY: begin
          if (start) begin
            // start has priority over a simultaneous query
            d_q     <= d_next;
            x_q     <= 5'd0;
            y_q     <= 5'd0;
            state_q <= (d_next == 5'd0) ? ST_READY : ST_SCAN;
          end else if ((state_q == ST_READY) && rd_req) begin
            rd_valid <= 1'b1;
            if (q_in_range) begin
              rd_mine  <= board_in[rd_x[3:0]][rd_y[3:0]];
              rd_count <= table_q[rd_y[IDX_W-1:0]][rd_x[IDX_W-1:0]];
              rd_oob   <= 1'b0;
            end else begin
              rd_mine  <= 1'b0;
              rd_count <= 4'd0;
              rd_oob   <= 1'b1;
            end
          end
        end
        ST_SCAN: begin
          table_q[y_q[IDX_W-1:0]][x_q[IDX_W-1:0]] <= nb_count;
          if (x_q == d_q - 5'd1) begin
            x_q <= 5'd0;
            if (y_q == d_q - 5'd1) begin
              state_q <= ST_READY;
            end else begin
              y_q <= y_q + 5'd1;
            end
          end else begin
            x_q <= x_q + 5'd1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

`ifdef MINE_READER_TOTAL_EN
  logic [8:0] total_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      total_q <= 9'd0;
    end else if (start && (state_q != ST_SCAN)) begin
      total_q <= 9'd0;
    end else if (state_q == ST_SCAN) begin
      total_q <= total_q + 9'(board_in[x_q[3:0]][y_q[3:0]]);
    end
  end

  assign total_mines = total_q;
`else
  assign total_mines = 9'd0;
`endif

endmodule

// File: doc/mine_reader.md
# mine_reader

Reads the mine board produced by the board generator and turns it into per-cell neighbour counts for the game logic and display. After `start`, it scans the active `dimension_size × dimension_size` area one cell per clock. For each cell it stores the 4-bit count of adjacent mines in an internal table. It then answers single-cell queries (mine flag plus neighbour count) through a request/valid port with one-cycle latency.

## Interface
- `MAX_DIM`, default 16: largest board side; table is `MAX_DIM × MAX_DIM × 4` bits.
- `clk`  input  1  system clock; the block uses this single clock.
- `rst`  input  1  reset, synchronous, active-high.
- `start`  input  1  one-cycle pulse; begins a scan (accepted in IDLE or READY).
- `dimension_size`  input  5  active board side; sampled on `start`.
- `board_in`  input  `[15:0][15:0]`  mine map indexed `[x][y]`; `1` = mine; must be stable from `start` until `ready`.
- `busy`  output  1  high while scanning.
- `ready`  output  1  table valid; queries served.
- `rd_req`  input  1  query strobe.
- `rd_x`, `rd_y`  input  5  queried cell.
- `rd_valid`  output  1  response strobe, one cycle.
- `rd_mine`  output  1  queried cell holds a mine.
- `rd_count`  output  4  adjacent mines, 0..8.
- `rd_oob`  output  1  queried coordinate is outside the active area.
- `total_mines`  output  9  mines inside the active area (see Configuration).

## Operation
- **FSM states:** IDLE, SCAN, READY.
- **Dimension capture:** on `start`, latch `d = min(dimension_size, MAX_DIM)`.
  - `d = 0`: go straight to READY with an empty area.
  - Otherwise: go to SCAN, clear `x = y = 0`, clear `total_mines`.
- **SCAN:** each cycle computes the count for `(x, y)` and writes it to the table.
  - The count sums the 8 neighbours `(x±1, y±1)`.
  - A neighbour is included only if both of its coordinates are in `0..d-1`.
  - Cells of `board_in` outside the active area are ignored, whatever their value.
  - `x` increments fastest; when `x` wraps `d-1 → 0`, `y` increments.
  - After `(d-1, d-1)` is written, the FSM moves to READY.
- **`start` behaviour:**
  - In READY: restarts the scan and drops `ready`.
  - In SCAN: ignored.
- **Queries:**
  - `rd_req` is honoured only in READY. In IDLE or SCAN it is dropped silently: no `rd_valid`, and the request is not queued.
  - In-range query (`rd_x < d` and `rd_y < d`): `rd_mine = board_in[rd_x][rd_y]`, `rd_count` = table entry, `rd_oob = 0`.
  - Out-of-range query: `rd_mine = 0`, `rd_count = 0`, `rd_oob = 1`.
- **Arithmetic:**
  - Neighbour sum is 4 bits and cannot overflow (maximum 8).
  - `total_mines` is 9 bits (maximum 256).

## Timing
- **Reset values:**
  - State IDLE.
  - `busy`, `ready`, `rd_valid`, `rd_mine`, `rd_oob` = 0.
  - `rd_count` = 0, `total_mines` = 0.
  - Table cleared to 0.
- **Reset mid-scan:** returns to IDLE in the same edge; the partial table is discarded (cleared).
- **Start to SCAN:** `start` sampled at edge N → `busy = 1` and `ready = 0` from N.
- **Scan writes:** the cell at scan index `k` (0-based) is written at edge `N+1+k`.
- **Scan completion:** `ready = 1` and `busy = 0` from edge `N + d²`.
  - d=8 → 64 cycles; d=10 → 100; d=16 → 256.
  - For `d = 0`, `ready = 1` from edge N.
- **Query latency:** `rd_req` sampled at edge M → response outputs registered at M, `rd_valid` high for exactly the following cycle.
  - Back-to-back requests give back-to-back responses.
  - Response fields hold their last value when `rd_valid = 0`.
- **Simultaneous `start` and `rd_req` in READY:** `start` wins; no response is produced.

## Configuration
- `MINE_READER_TOTAL_EN` defined:
  - Compiles in the `total_mines` accumulator.
  - During SCAN it adds `board_in[x][y]` for each scanned cell.
  - Final value is stable from `ready` onward.
- Not defined:
  - No accumulator logic.
  - `total_mines` is tied to 0.
  - All other behaviour is identical.

## Test plan
1. **Reset:** assert `rst` for 2 cycles, driving random `rd_req` and `start` → all outputs 0, no `rd_valid`.
2. **Empty board:** all-zero `board_in`, d=8, `start` → `busy` for 64 cycles, `ready` at +64. Query (0,0) and (7,7) → `rd_count = 0`, `rd_mine = 0`. `total_mines = 0`.
3. **Single mine:** mine at (3,3), d=8.
   - Query (2,2), (4,3), (4,4) → `rd_count = 1`.
   - Query (3,3) → `rd_mine = 1`, `rd_count = 0`.
   - Query (5,5) → `rd_count = 0`.
   - `total_mines = 1` with the macro enabled, 0 without.
4. **Corner and masking:** mines at (0,1), (1,0), (1,1) plus a stray mine at (10,10); d=10.
   - Query (0,0) → `rd_count = 3`.
   - Query (9,9) → `rd_count = 0`.
   - `total_mines = 3`.
5. **Query gating:**
   - `rd_req` during SCAN → no `rd_valid`.
   - After `ready`, query (8,2) with d=8 → `rd_oob = 1`, `rd_count = 0`, `rd_mine = 0`.
   - Back-to-back queries (1,1) then (3,3) → two consecutive `rd_valid` cycles with the correct data.
6. **Restart and abort:**
   - `start` in READY with d=16, all-ones board → `ready` drops; after 256 cycles, query (0,0) → 3, (5,5) → 8, (15,0) → 3.
   - `rst` at scan cycle 100 → IDLE, table zero, `ready` stays 0.
